mod_exp_engine: RTL
===================

# mod_exp_engine

Parametrised word-serial Montgomery modular exponentiation engine computing result = base^exponent mod modulus with a left-to-right square-and-multiply schedule. It is the next generation of the fixed 256/32-bit RSA datapath. Widths are generic, operands are latched by a start/done handshake, and conversion into and out of the Montgomery domain is done internally. Every product is fully reduced, and an even modulus is flagged as an error. It sits between the key/operand register file and the crypto result FIFO.

## Interface
- N_BITS, 256, operand/modulus width; must be a multiple of W_BITS
- W_BITS, 32, multiplier word width (digit size)
- E_BITS, 32, exponent width
- Reset rstn, asynchronous, active-low; clock clk.
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only when busy=0
- base  in  N_BITS  message, must be < modulus
- modulus  in  N_BITS  M, odd, M < 2^N_BITS
- exponent  in  E_BITS  exponent, processed MSB first
- mp  in  W_BITS  -M^-1 mod 2^W_BITS
- r2  in  N_BITS  R^2 mod M, where R = 2^N_BITS
- one_m  in  N_BITS  R mod M
- busy  out  1  high from the accept cycle until done
- done  out  1  one-cycle pulse; result and err valid
- err  out  1  valid with done; 1 = even modulus
- result  out  N_BITS  held until the next accepted start

## Operation
- Reset values: busy=0, done=0, err=0, result=0, FSM=IDLE.
- Operand capture: on accept, all operands are registered. Input changes after accept have no effect.
- start while busy=1 is ignored, with no queueing.
- Error check: if modulus[0]=0 at accept, go to ERR. The next cycle gives done=1, err=1, result=0, then IDLE.
- FSM states: IDLE -> TO_MONT -> (SQR -> [MUL]) per exponent bit -> FROM_MONT -> FIN -> IDLE. ERR is the side branch.
- TO_MONT computes x = MM(base, r2). The accumulator is loaded with one_m.
- SQR for bit i (E_BITS-1 down to 0) computes acc = MM(acc, acc). If exponent[i]=1, MUL follows with acc = MM(acc, x).
- FROM_MONT computes result = MM(acc, 1).
- MM(a,b) = a·b·R^-1 mod M:
  - K = N_BITS/W_BITS iterations, with T=0 at the start.
  - Each iteration: q = ((T + a·b_i) mod 2^W)·mp mod 2^W, then T = (T + a·b_i + q·M) >> W_BITS.
  - The intermediate sum is N_BITS+W_BITS+2 bits wide, and T stays < 2M.
  - A final conditional subtract (T ≥ M → T−M) makes every output < M.
- exponent=0 gives result 1 mod M. M=1 gives result 0.

## Timing
- Multiplier latency:
  - Issue at edge t.
  - Word iterations at edges t+1..t+K.
  - Conditional subtract and mm_done at edge t+K+1.
  - The FSM issues the next MM on the edge after mm_done, so each MM costs K+2 cycles.
- Without the scan feature: done rises (2+E_BITS+popcount(exponent))·(K+2)+1 cycles after the accept edge. The latency depends only on the popcount.
- busy falls in the same cycle that done is high.
- Reset mid-operation: everything returns to reset values immediately. No done is issued for the aborted job.

## Configuration
- MODEXP_SCAN_EN defined: bits above the MSB set in exponent are skipped. The skip takes one cycle per leading zero at 1 bit/cycle, and SQR and MUL are not issued for those bits. Latency drops to lz + (2+E_BITS−lz+popcount)·(K+2)+1, where lz is the number of leading zeros.
- MODEXP_SCAN_EN undefined: all E_BITS bits are processed, including leading zeros. This gives a timing profile independent of the exponent's magnitude.

## Structure
- Package modexp_pkg holds:
  - the FSM state enum
  - the derived constant K = N_BITS/W_BITS
  - the intermediate width N_BITS+W_BITS+2
- Sub-module mont_mul_word is the word-serial Montgomery multiplier:
  - inputs: start, a, b, modulus, mp
  - outputs: mm_done, p
  - it is parametrised by N_BITS and W_BITS.
- Top level = FSM, operand registers, exponent bit counter, accumulator.

## Test plan
- N_BITS=64, W_BITS=16, E_BITS=8. The bench model supplies mp, r2 and one_m. base=3, exp=5, M=7 -> result=5, err=0; latency equals the formula with popcount=2.
- base=2, exp=10, M=1000003 -> result=1024. A start pulsed during busy is ignored, and only one done is seen.
- exp=0, M=1000003 -> result=1. Also M=1, exp=7 -> result=0.
- M=10 (even) -> done one cycle after the accept cycle, err=1, result=0.
- N_BITS=256, W_BITS=32, E_BITS=32, M = 256-bit random odd, exp=65537 -> matches the bench model. Operands changed after accept do not alter the result.
- rstn pulsed low mid-SQR -> busy=0, done=0, result=0. A following job with base=3, exp=5, M=7 completes with 5.

Source files
------------

// File: rtl/modexp_pkg.sv
// modexp_pkg: shared FSM states and derived sizes for the Montgomery exponentiation engine
package modexp_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_TO_MONT, S_SCAN, S_SQR, S_MUL, S_FROM_MONT, S_FIN, S_ERR
   } state_e;
   localparam int N_BITS_DEF = 256;
   localparam int W_BITS_DEF = 32;
   localparam int E_BITS_DEF = 32;
   localparam int K_DEF      = N_BITS_DEF / W_BITS_DEF;
   function automatic int num_words(input int n, input int w);
      return n / w;
   endfunction
   function automatic int inter_width(input int n, input int w);
      return n + w + 2;
   endfunction
endpackage

// File: rtl/mont_mul_word.sv
// mont_mul_word: word-serial Montgomery multiplier, p = a*b*R^-1 mod M, fully reduced
module mont_mul_word import modexp_pkg::*; #(
   parameter int N_BITS = N_BITS_DEF,
   parameter int W_BITS = W_BITS_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start_i,
   input  logic [N_BITS-1:0] a_i,
   input  logic [N_BITS-1:0] b_i,
   input  logic [N_BITS-1:0] modulus_i,
   input  logic [W_BITS-1:0] mp_i,
   output logic              mm_done_o,
   output logic [N_BITS-1:0] p_o
);
   localparam int K  = num_words(N_BITS, W_BITS);
   localparam int IW = inter_width(N_BITS, W_BITS);
   localparam int CW = $clog2(K) + 1;
   logic [N_BITS-1:0] a_q, b_q, m_q, p_q;
   logic [W_BITS-1:0] mp_q, q;
   logic [N_BITS:0]   t_q, t_d;
   logic [IW-1:0]     sum_ab, sum_q;
   logic [CW-1:0]     cnt_q;
   logic              run_q, fin_q, done_q;
   assign sum_ab = IW'(t_q) + IW'(a_q) * IW'(b_q[W_BITS-1:0]);
   assign q      = W_BITS'(sum_ab[W_BITS-1:0] * mp_q);
   assign sum_q  = sum_ab + IW'(q) * IW'(m_q);
   assign t_d    = (N_BITS+1)'(sum_q >> W_BITS);
   assign mm_done_o = done_q;
   assign p_o       = p_q;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         mp_q   <= '0;
         t_q    <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         fin_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= fin_q;
         fin_q  <= run_q && cnt_q == CW'(K-1);
         if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            m_q   <= modulus_i;
            mp_q  <= mp_i;
            t_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
         end else if (run_q) begin
            t_q   <= t_d;
            b_q   <= b_q >> W_BITS;
            cnt_q <= cnt_q + 1'b1;
            run_q <= cnt_q != CW'(K-1);
         end
         // T < 2M here, so one conditional subtract fully reduces
         if (fin_q) p_q <= t_q >= {1'b0, m_q} ? N_BITS'(t_q - {1'b0, m_q}) : t_q[N_BITS-1:0];
      end
endmodule

// File: rtl/mod_exp_engine.sv
// mod_exp_engine: left-to-right Montgomery modular exponentiation, base^exponent mod modulus
// MODEXP_SCAN_EN skips leading zero exponent bits at one bit per cycle
module mod_exp_engine import modexp_pkg::*; #(
   parameter int N_BITS = N_BITS_DEF,
   parameter int W_BITS = W_BITS_DEF,
   parameter int E_BITS = E_BITS_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start_i,
   input  logic [N_BITS-1:0] base_i,
   input  logic [N_BITS-1:0] modulus_i,
   input  logic [E_BITS-1:0] exponent_i,
   input  logic [W_BITS-1:0] mp_i,
   input  logic [N_BITS-1:0] r2_i,
   input  logic [N_BITS-1:0] one_m_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [N_BITS-1:0] result_o
);
   localparam int BW = $clog2(E_BITS) + 1;
   state_e            state_q, state_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [E_BITS-1:0] exp_q;
   logic [N_BITS-1:0] mod_q, x_q, acc_q, result_q, acc_n, mm_a, mm_b, mm_m, mm_p;
   logic [W_BITS-1:0] mp_q, mm_mp;
   logic              mm_start, mm_done, done_q, err_q, accept, cur_bit, idle;
   assign idle    = state_q == S_IDLE;
   assign accept  = start_i && idle;
   assign cur_bit = |(exp_q & (E_BITS'(1) << bit_q));
   assign acc_n   = (state_q == S_SQR || state_q == S_MUL) ? mm_p : acc_q;
   // the first product is issued straight from the ports on the accept edge
   assign mm_a  = idle ? base_i : acc_n;
   assign mm_b  = idle ? r2_i : state_d == S_MUL ? x_q : state_d == S_FROM_MONT ? N_BITS'(1) : acc_n;
   assign mm_m  = idle ? modulus_i : mod_q;
   assign mm_mp = idle ? mp_i : mp_q;
   assign busy_o   = !idle;
   assign done_o   = done_q;
   assign err_o    = err_q;
   assign result_o = result_q;
   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      mm_start = 1'b0;
      case (state_q)
         S_IDLE: if (start_i) begin
            state_d  = modulus_i[0] ? S_TO_MONT : S_ERR;
            bit_d    = BW'(E_BITS-1);
            mm_start = modulus_i[0];
         end
         S_TO_MONT: if (mm_done) begin
`ifdef MODEXP_SCAN_EN
            state_d  = cur_bit ? S_SQR : S_SCAN;
            mm_start = cur_bit;
            bit_d    = cur_bit ? bit_q : bit_q - 1'b1;
`else
            state_d  = S_SQR;
            mm_start = 1'b1;
`endif
         end
         // bit index wraps to all-ones once every bit was zero
         S_SCAN: begin
            state_d  = bit_q == '1 ? S_FROM_MONT : cur_bit ? S_SQR : S_SCAN;
            mm_start = bit_q == '1 || cur_bit;
            bit_d    = (bit_q == '1 || cur_bit) ? bit_q : bit_q - 1'b1;
         end
         S_SQR: if (mm_done) begin
            mm_start = 1'b1;
            state_d  = cur_bit ? S_MUL : bit_q == '0 ? S_FROM_MONT : S_SQR;
            bit_d    = cur_bit ? bit_q : bit_q - 1'b1;
         end
         S_MUL: if (mm_done) begin
            mm_start = 1'b1;
            state_d  = bit_q == '0 ? S_FROM_MONT : S_SQR;
            bit_d    = bit_q - 1'b1;
         end
         S_FROM_MONT: if (mm_done) state_d = S_FIN;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state_q  <= S_IDLE;
         bit_q    <= '0;
         exp_q    <= '0;
         mod_q    <= '0;
         mp_q     <= '0;
         x_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         done_q  <= state_q == S_FIN || state_q == S_ERR;
         if (accept) begin
            exp_q    <= exponent_i;
            mod_q    <= modulus_i;
            mp_q     <= mp_i;
            acc_q    <= one_m_i;
            result_q <= '0;
            err_q    <= !modulus_i[0];
         end
         if (mm_done && state_q == S_TO_MONT) x_q <= mm_p;
         if (mm_done && (state_q == S_SQR || state_q == S_MUL)) acc_q <= mm_p;
         if (mm_done && state_q == S_FROM_MONT) result_q <= mm_p;
      end
   mont_mul_word #(.N_BITS(N_BITS), .W_BITS(W_BITS)) u_mm (
      .clk       (clk),
      .rstn      (rstn),
      .start_i   (mm_start),
      .a_i       (mm_a),
      .b_i       (mm_b),
      .modulus_i (mm_m),
      .mp_i      (mm_mp),
      .mm_done_o (mm_done),
      .p_o       (mm_p)
   );
endmodule
